// File: rtl/video_timing_gen_if.sv
// Raster generator bundle: pixel-fetch request/return plus the encoder-facing outputs.
// master = timing generator, slave = pixel source and TMDS encoder side.
interface video_timing_gen_if;
  logic [9:0] fetchX;
  logic [9:0] fetchY;
  logic       fetchValid;
  logic [7:0] pixelInR;
  logic [7:0] pixelInG;
  logic [7:0] pixelInB;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       DE;
  logic [1:0] controlBus;
  logic       frameStart;

  modport master (
    output fetchX, fetchY, fetchValid, red, green, blue, DE, controlBus, frameStart,
    input  pixelInR, pixelInG, pixelInB
  );

  modport slave (
    input  fetchX, fetchY, fetchValid, red, green, blue, DE, controlBus, frameStart,
    output pixelInR, pixelInG, pixelInB
  );
endinterface

// File: rtl/video_timing_gen.sv
// video_timing_gen: pixel-clock raster generator with fetch stage and registered output stage.
// Define TEST_PATTERN_EN to replace pixelIn* with eight internally generated vertical colour bars.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic               pixelClk,
  input  logic               reset,
  input  logic               enable,
  video_timing_gen_if.master vidBus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_FPO_LAST = 10'(H_ACTIVE + H_FP - 1);
  localparam logic [9:0] H_SYN_LAST = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_FPO_LAST = 10'(V_ACTIVE + V_FP - 1);
  localparam logic [9:0] V_SYN_LAST = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

  localparam logic HS_ON  = HS_POL;
  localparam logic HS_OFF = !HS_POL;
  localparam logic VS_ON  = VS_POL;
  localparam logic VS_OFF = !VS_POL;

  // Counters are 10 bits wide, so a raster that does not fit must not elaborate.
  generate
    if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : gRasterTooLarge
      $error("video_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
  endgenerate

  typedef enum logic [1:0] {
    H_ACT = 2'd0,
    H_FPO = 2'd1,
    H_SYN = 2'd2,
    H_BPO = 2'd3
  } lineState_e;

  typedef enum logic [1:0] {
    V_ACT = 2'd0,
    V_FPO = 2'd1,
    V_SYN = 2'd2,
    V_BPO = 2'd3
  } frameState_e;

  logic [9:0]  hCount_r;
  logic [9:0]  vCount_r;
  lineState_e  lineState_r;
  frameState_e frameState_r;

  logic        fetchValid_r;
  logic [9:0]  fetchX_r;
  logic [9:0]  fetchY_r;
  logic        hSyncAct_r;
  logic        vSyncAct_r;

  logic        de_r;
  logic [7:0]  red_r;
  logic [7:0]  green_r;
  logic [7:0]  blue_r;
  logic [1:0]  controlBus_r;
  logic        frameStart_r;

  logic [7:0]  pixR_s;
  logic [7:0]  pixG_s;
  logic [7:0]  pixB_s;

  // Raster counters, line/frame FSMs and the fetch-stage registers they feed
  always_ff @(posedge pixelClk) begin
    if (reset) begin
      hCount_r     <= 10'd0;
      vCount_r     <= 10'd0;
      lineState_r  <= H_ACT;
      frameState_r <= V_ACT;
      fetchValid_r <= 1'b0;
      fetchX_r     <= 10'd0;
      fetchY_r     <= 10'd0;
      hSyncAct_r   <= 1'b0;
      vSyncAct_r   <= 1'b0;
    end else if (enable) begin
      fetchValid_r <= (lineState_r == H_ACT) && (frameState_r == V_ACT);
      fetchX_r     <= ((lineState_r == H_ACT) && (frameState_r == V_ACT)) ? hCount_r : 10'd0;
      fetchY_r     <= ((lineState_r == H_ACT) && (frameState_r == V_ACT)) ? vCount_r : 10'd0;
      hSyncAct_r   <= (lineState_r == H_SYN);
      vSyncAct_r   <= (frameState_r == V_SYN);

      case (lineState_r)
        H_ACT:   if (hCount_r == H_ACT_LAST) lineState_r <= H_FPO;
        H_FPO:   if (hCount_r == H_FPO_LAST) lineState_r <= H_SYN;
        H_SYN:   if (hCount_r == H_SYN_LAST) lineState_r <= H_BPO;
        H_BPO:   if (hCount_r == H_LAST)     lineState_r <= H_ACT;
        default: lineState_r <= H_ACT;
      endcase

      // Vertical state only moves on the line wrap, so vsync edges land on line starts.
      if (hCount_r == H_LAST) begin
        hCount_r <= 10'd0;
        vCount_r <= (vCount_r == V_LAST) ? 10'd0 : (vCount_r + 10'd1);
        case (frameState_r)
          V_ACT:   if (vCount_r == V_ACT_LAST) frameState_r <= V_FPO;
          V_FPO:   if (vCount_r == V_FPO_LAST) frameState_r <= V_SYN;
          V_SYN:   if (vCount_r == V_SYN_LAST) frameState_r <= V_BPO;
          V_BPO:   if (vCount_r == V_LAST)     frameState_r <= V_ACT;
          default: frameState_r <= V_ACT;
        endcase
      end else begin
        hCount_r <= hCount_r + 10'd1;
      end
    end
  end

`ifdef TEST_PATTERN_EN
  logic [9:0] barIdx_s;
  assign barIdx_s = fetchX_r / 10'(H_ACTIVE / 8);

  // Colour-bar source replacing returned pixel data, blanked outside the active area
  always_comb begin
    pixR_s = 8'h00;
    pixG_s = 8'h00;
    pixB_s = 8'h00;
    if (fetchValid_r) begin
      case (barIdx_s)
        10'd0:   begin pixR_s = 8'hFF; pixG_s = 8'hFF; pixB_s = 8'hFF; end
        10'd1:   begin pixR_s = 8'hFF; pixG_s = 8'hFF; pixB_s = 8'h00; end
        10'd2:   begin pixR_s = 8'h00; pixG_s = 8'hFF; pixB_s = 8'hFF; end
        10'd3:   begin pixR_s = 8'h00; pixG_s = 8'hFF; pixB_s = 8'h00; end
        10'd4:   begin pixR_s = 8'hFF; pixG_s = 8'h00; pixB_s = 8'hFF; end
        10'd5:   begin pixR_s = 8'hFF; pixG_s = 8'h00; pixB_s = 8'h00; end
        10'd6:   begin pixR_s = 8'h00; pixG_s = 8'h00; pixB_s = 8'hFF; end
        default: begin pixR_s = 8'h00; pixG_s = 8'h00; pixB_s = 8'h00; end
      endcase
    end else begin
      pixR_s = 8'h00;
      pixG_s = 8'h00;
      pixB_s = 8'h00;
    end
  end
`else
  // Returned pixel data, blanked outside the active area
  always_comb begin
    pixR_s = 8'h00;
    pixG_s = 8'h00;
    pixB_s = 8'h00;
    if (fetchValid_r) begin
      pixR_s = vidBus.pixelInR;
      pixG_s = vidBus.pixelInG;
      pixB_s = vidBus.pixelInB;
    end else begin
      pixR_s = 8'h00;
      pixG_s = 8'h00;
      pixB_s = 8'h00;
    end
  end
`endif

  // Output stage one cycle behind fetch; frameStart never repeats across a stall
  always_ff @(posedge pixelClk) begin
    if (reset) begin
      de_r         <= 1'b0;
      red_r        <= 8'h00;
      green_r      <= 8'h00;
      blue_r       <= 8'h00;
      controlBus_r <= {VS_OFF, HS_OFF};
      frameStart_r <= 1'b0;
    end else if (enable) begin
      de_r         <= fetchValid_r;
      red_r        <= pixR_s;
      green_r      <= pixG_s;
      blue_r       <= pixB_s;
      controlBus_r <= {(vSyncAct_r ? VS_ON : VS_OFF), (hSyncAct_r ? HS_ON : HS_OFF)};
      frameStart_r <= fetchValid_r && (fetchX_r == 10'd0) && (fetchY_r == 10'd0);
    end else begin
      frameStart_r <= 1'b0;
    end
  end

  assign vidBus.fetchX     = fetchX_r;
  assign vidBus.fetchY     = fetchY_r;
  assign vidBus.fetchValid = fetchValid_r;
  assign vidBus.red        = red_r;
  assign vidBus.green      = green_r;
  assign vidBus.blue       = blue_r;
  assign vidBus.DE         = de_r;
  assign vidBus.controlBus = controlBus_r;
  assign vidBus.frameStart = frameStart_r;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a reduced raster (48x15) so whole frames stay short.
// Expected outputs come from an arithmetic raster model; honours TEST_PATTERN_EN.
module tb_video_timing_gen;
  localparam int HA = 32, HFP = 4, HSW = 6, HBP = 6;
  localparam int VA = 8,  VFP = 2, VSW = 2, VBP = 3;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam bit HSP = 1'b0;
  localparam bit VSP = 1'b0;
  localparam logic [27:0] RST_VEC = {1'b0, 24'h000000, !VSP, !HSP, 1'b0};

  logic pixelClk = 1'b0;
  logic reset    = 1'b1;
  logic enable   = 1'b1;

  video_timing_gen_if vidBus();

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP)
  ) dut (
    .pixelClk(pixelClk),
    .reset(reset),
    .enable(enable),
    .vidBus(vidBus)
  );

  // Pixel source: answers the fetch address within the fetch cycle
  assign vidBus.pixelInR = vidBus.fetchX[7:0];
  assign vidBus.pixelInG = vidBus.fetchY[7:0];
  assign vidBus.pixelInB = vidBus.fetchX[7:0] ^ 8'h5A;

  always #5 pixelClk = ~pixelClk;

  logic [27:0] obs;
  logic [20:0] obsFetch;
  assign obs      = {vidBus.DE, vidBus.red, vidBus.green, vidBus.blue, vidBus.controlBus, vidBus.frameStart};
  assign obsFetch = {vidBus.fetchValid, vidBus.fetchX, vidBus.fetchY};

  int vecCount  = 0;
  int missCount = 0;
  logic [27:0] expQ[$];
  logic [27:0] lastOut;
  logic [20:0] lastFetch;
  int mh, mv;

  int cyc = 0, fsPrev = 0, fsGap = 0, deCnt = 0, deLine = 0;
  int hsLowCnt = 0, vsLowCnt = 0, hsFallOff = -1;
  bit winOpen = 1'b0, winDone = 1'b0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    vecCount++;
    if (got !== want) begin
      missCount++;
      $display("FAIL %s: got %h, expected %h (model h=%0d v=%0d)", tag, got, want, mh, mv);
    end
  endtask

`ifdef TEST_PATTERN_EN
  function automatic logic [23:0] barColour(input int bar);
    case (bar)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction
`endif

  function automatic logic [27:0] expOut(input int h, input int v);
    logic        act, hs, vs;
    logic [7:0]  hb, vb;
    logic [23:0] rgb;
    act = (h < HA) && (v < VA);
    hb  = 8'(h);
    vb  = 8'(v);
    hs  = ((h >= HA + HFP) && (h < HA + HFP + HSW)) ? HSP : !HSP;
    vs  = ((v >= VA + VFP) && (v < VA + VFP + VSW)) ? VSP : !VSP;
`ifdef TEST_PATTERN_EN
    rgb = barColour(h / (HA / 8));
`else
    rgb = {hb, vb, hb ^ 8'h5A};
`endif
    if (!act) rgb = 24'h000000;
    return {act, rgb, vs, hs, (h == 0) && (v == 0)};
  endfunction

  task automatic measure();
    cyc++;
    if (vidBus.frameStart && winOpen && !winDone) begin
      winDone = 1'b1;
      fsGap   = cyc - fsPrev;
    end else if (vidBus.frameStart && !winOpen) begin
      winOpen = 1'b1;
      fsPrev  = cyc;
    end
    if (winOpen && !winDone) begin
      if (vidBus.DE) begin
        deCnt++;
        if (cyc - fsPrev < HT) deLine++;
      end
      if (vidBus.controlBus[0] == HSP) begin
        hsLowCnt++;
        if (hsFallOff < 0) hsFallOff = cyc - fsPrev;
      end
      if (vidBus.controlBus[1] == VSP) vsLowCnt++;
    end
  endtask

  // One clock: expectation pushed when the raster position is driven, popped when its output appears
  task automatic cycle(input logic en);
    logic [27:0] e;
    logic [20:0] ef;
    logic        fv;
    enable = en;
    if (en) begin
      fv = (mh < HA) && (mv < VA);
      ef = fv ? {1'b1, 10'(mh), 10'(mv)} : 21'h0;
      expQ.push_back(expOut(mh, mv));
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end
    end else begin
      ef = lastFetch;
    end
    @(posedge pixelClk);
    #1;
    if (en) begin
      e = expQ.pop_front();
      lastOut = e;
      checkVal("out", 32'(obs), 32'(e));
      checkVal("fetch", 32'(obsFetch), 32'(ef));
    end else begin
      checkVal("holdOut", 32'(obs), 32'({lastOut[27:1], 1'b0}));
      checkVal("holdFetch", 32'(obsFetch), 32'(ef));
    end
    lastFetch = ef;
    measure();
  endtask

  task automatic applyReset(input int n);
    reset  = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge pixelClk);
      #1;
      checkVal("rstOut", 32'(obs), 32'(RST_VEC));
      checkVal("rstFetch", 32'(obsFetch), 32'd0);
    end
    reset = 1'b0;
    mh = 0;
    mv = 0;
    expQ.delete();
    expQ.push_back(RST_VEC);
    lastOut   = RST_VEC;
    lastFetch = 21'h0;
  endtask

  initial begin
    mh = 0;
    mv = 0;
    applyReset(3);

    // Two full frames uninterrupted, including the simultaneous h/v wrap
    for (int i = 0; i < 2 * HT * VT + 10; i++) cycle(1'b1);
    checkVal("fsGap", 32'(fsGap), 32'(HT * VT));
    checkVal("deLine", 32'(deLine), 32'(HA));
    checkVal("deFrame", 32'(deCnt), 32'(HA * VA));
    checkVal("hsLowFrame", 32'(hsLowCnt), 32'(HSW * VT));
    checkVal("hsOffset", 32'(hsFallOff), 32'(HA + HFP));
    checkVal("vsLowFrame", 32'(vsLowCnt), 32'(VSW * HT));

    // Mid-line stall of 50 cycles, then resume
    for (int i = 0; i < 2 * HT * VT && !(mh == 20 && mv == 3); i++) cycle(1'b1);
    checkVal("reachStall", 32'({mh == 20, mv == 3}), 32'b11);
    for (int i = 0; i < 50; i++) cycle(1'b0);
    for (int i = 0; i < 2 * HT; i++) cycle(1'b1);

    // Irregular enable pattern across a frame boundary
    for (int i = 0; i < 1000; i++) cycle(logic'($urandom_range(0, 3) != 0));

    // Reset in the vertical front porch during horizontal back porch, then a clean restart
    for (int i = 0; i < 2 * HT * VT && !(mh == 44 && mv == 9); i++) cycle(1'b1);
    checkVal("reachReset", 32'({mh == 44, mv == 9}), 32'b11);
    applyReset(1);
    for (int i = 0; i < HT * VT + HT; i++) cycle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule
